// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU control decode stage
//
// Contents:
//   ALU_* codes   4-bit ALU control values driven to the ALU
//   OP_CMP        major opcode of the compare instruction
//   opclass_e     instruction class carried with each decoded entry
//   alu_entry_t   decoded entry as stored in the stage FIFO
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_SHIFT = 4'h8;

    localparam logic [5:0] OP_CMP = 6'b110101;

    typedef enum logic [1:0] {
        CLS_LOAD  = 2'd0,
        CLS_STORE = 2'd1,
        CLS_CTL   = 2'd2,
        CLS_ALU   = 2'd3
    } opclass_e;

    typedef struct packed {
        logic [3:0] alu_cnt;
        logic       alu_use;
        logic       cmp;
        opclass_e   op_class;
    } alu_entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational major-opcode to ALU control decode
//
// Ports:
//   in_op  in  6            major opcode, instruction bits [5:0]
//   entry  out alu_entry_t  decoded ALU code, usage/compare flags and class
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [5:0] in_op,
    output alu_entry_t entry
);

    always_comb begin
        entry.alu_cnt  = ALU_ADD;
        entry.alu_use  = 1'b1;
        entry.cmp      = 1'b0;
        entry.op_class = CLS_LOAD;
        unique case (in_op[5:4])
            2'b00: begin
                entry.op_class = CLS_LOAD;
            end
            2'b01: begin
                entry.op_class = CLS_STORE;
            end
            2'b10: begin
                // Only the 10111x control ops need the ALU (address/compare
                // work); every other control op bypasses it.
                entry.op_class = CLS_CTL;
                entry.alu_use  = (in_op[3:1] == 3'b111);
            end
            default: begin
                // ALU/IO group: the low nibble is the ALU code directly,
                // except CMP, which subtracts and suppresses write-back.
                entry.op_class = CLS_ALU;
                if (in_op == OP_CMP) begin
                    entry.alu_cnt = ALU_SUB;
                    entry.cmp     = 1'b1;
                end else begin
                    entry.alu_cnt = in_op[3:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered, flow-controlled ALU control decode stage
//
// Parameters:
//   DEPTH      decoded-entry slots (power of two, >= 2)
//   MC_MASK    bit k set => ALU code k is multi-cycle
//   MC_CYCLES  stall cycles after a multi-cycle op issues (1..15)
//
// Ports:
//   clk          in   1  clock
//   rst_n        in   1  asynchronous active-low reset
//   flush        in   1  synchronous pipeline flush
//   in_valid     in   1  opcode offered
//   in_ready     out  1  stage can accept
//   in_op        in   6  major opcode
//   out_valid    out  1  decoded entry offered
//   out_ready    in   1  ALU accepts
//   out_alu_cnt  out  4  ALU control code
//   out_alu_use  out  1  instruction uses the ALU
//   out_cmp      out  1  compare, result not written back
//   out_class    out  2  0 load, 1 store, 2 branch/ctl, 3 ALU/IO
//   busy         out  1  multi-cycle stall in progress
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] MC_MASK   = 16'h0F00,
    parameter int          MC_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_alu_cnt,
    output logic       out_alu_use,
    output logic       out_cmp,
    output logic [1:0] out_class,
    output logic       busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [3:0]       MC_LOAD = 4'(MC_CYCLES);

    alu_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       mc_cnt;

    alu_entry_t dec_entry;
    alu_entry_t head;
    alu_entry_t hold_q;
    alu_entry_t out_entry;

    logic push;
    logic pop;
    logic mc_start;

    alu_ctrl_decode u_decode (
        .in_op (in_op),
        .entry (dec_entry)
    );

    // Readiness depends on registered count only, so a pop in the full
    // cycle cannot re-open the input in that same cycle.
    assign in_ready  = (count < DEPTH_C) && !flush;
    assign push      = in_valid && in_ready;
    assign out_valid = (count != '0) && (mc_cnt == 4'd0);
    // A pop offered during flush is not a transfer.
    assign pop       = out_valid && out_ready && !flush;

    assign head      = mem[rd_ptr];
    // When empty the outputs keep whatever was last presented.
    assign out_entry = (count != '0) ? head : hold_q;
    assign mc_start  = pop && head.alu_use && MC_MASK[head.alu_cnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= dec_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= out_entry;
        end
    end

    // out_valid is low while mc_cnt is nonzero, so a load and a decrement
    // can never be requested in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_cnt <= 4'd0;
        end else if (flush) begin
            mc_cnt <= 4'd0;
        end else if (mc_start) begin
            mc_cnt <= MC_LOAD;
        end else if (mc_cnt != 4'd0) begin
            mc_cnt <= mc_cnt - 4'd1;
        end
    end

    assign busy        = (mc_cnt != 4'd0);
    assign out_alu_cnt = out_entry.alu_cnt;
    assign out_alu_use = out_entry.alu_use;
    assign out_cmp     = out_entry.cmp;
    assign out_class   = out_entry.op_class;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - self-checking bench for alu_ctrl_stage
module tb_alu_ctrl_stage;

    localparam int          DEPTH     = 2;
    localparam logic [15:0] MC_MASK   = 16'h0F00;
    localparam int          MC_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_alu_cnt;
    logic       out_alu_use;
    logic       out_cmp;
    logic [1:0] out_class;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: queue of expected entries packed as
    // {cnt[3:0], use, cmp, class[1:0]}, remaining stall cycles, last shown.
    logic [7:0] ref_q[$];
    int         ref_stall;
    logic [7:0] ref_last;

    alu_ctrl_stage #(
        .DEPTH     (DEPTH),
        .MC_MASK   (MC_MASK),
        .MC_CYCLES (MC_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_cnt (out_alu_cnt),
        .out_alu_use (out_alu_use),
        .out_cmp     (out_cmp),
        .out_class   (out_class),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_decode(input int op);
        int grp;
        int cnt;
        int use_alu;
        int cmp;
        grp     = op / 16;
        cnt     = 0;
        use_alu = 1;
        cmp     = 0;
        if (grp == 2) begin
            use_alu = (op == 46 || op == 47) ? 1 : 0;
        end else if (grp == 3) begin
            if (op == 53) begin
                cnt = 1;
                cmp = 1;
            end else begin
                cnt = op % 16;
            end
        end
        return 8'(cnt * 16 + use_alu * 8 + cmp * 4 + grp);
    endfunction

    function automatic bit ref_is_mc(input logic [7:0] e);
        int code;
        code = int'(e[7:4]);
        return e[3] && MC_MASK[code];
    endfunction

    task automatic ref_reset();
        ref_q.delete();
        ref_stall = 0;
        ref_last  = 8'h00;
    endtask

    // One clock cycle: drive, check against the reference, advance both.
    task automatic step(input logic v, input logic [5:0] op, input logic rdy, input logic fl);
        logic [7:0] exp_e;
        logic [7:0] popped;
        bit         exp_in_ready;
        bit         exp_out_valid;
        bit         do_push;
        bit         do_pop;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        out_ready = rdy;
        flush     = fl;
        #1;
        exp_in_ready  = (ref_q.size() < DEPTH) && !fl;
        exp_out_valid = (ref_q.size() != 0) && (ref_stall == 0);
        exp_e         = (ref_q.size() != 0) ? ref_q[0] : ref_last;
        check("in_ready",  32'(in_ready),  32'(exp_in_ready));
        check("out_valid", 32'(out_valid), 32'(exp_out_valid));
        check("busy",      32'(busy),      32'(ref_stall != 0));
        check("fields",    32'({out_alu_cnt, out_alu_use, out_cmp, out_class}), 32'(exp_e));
        do_push  = v && exp_in_ready;
        do_pop   = exp_out_valid && rdy && !fl;
        ref_last = exp_e;
        @(posedge clk);
        if (fl) begin
            ref_q.delete();
            ref_stall = 0;
        end else begin
            if (do_pop) begin
                popped = ref_q.pop_front();
                if (ref_is_mc(popped)) begin
                    ref_stall = MC_CYCLES;
                end
            end else if (ref_stall > 0) begin
                ref_stall--;
            end
            if (do_push) begin
                ref_q.push_back(ref_decode(int'(op)));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 6'd0;
        out_ready = 1'b0;
        ref_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_fields",    32'({out_alu_cnt, out_alu_use, out_cmp, out_class}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back pushes, one per cycle, drained immediately.
        step(1'b1, 6'b110010, 1'b1, 1'b0);
        step(1'b1, 6'b000111, 1'b1, 1'b0);
        step(1'b1, 6'b011000, 1'b1, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0);

        // CMP and control-class decode.
        step(1'b1, 6'b110101, 1'b1, 1'b0);
        step(1'b1, 6'b101110, 1'b1, 1'b0);
        step(1'b1, 6'b100011, 1'b1, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0);

        // Backpressure: fill, then drain while still offering an op.
        step(1'b1, 6'b110001, 1'b0, 1'b0);
        step(1'b1, 6'b110010, 1'b0, 1'b0);
        step(1'b1, 6'b110011, 1'b0, 1'b0);
        step(1'b1, 6'b110011, 1'b1, 1'b0);
        step(1'b1, 6'b110100, 1'b1, 1'b0);
        repeat (3) step(1'b0, 6'd0, 1'b1, 1'b0);

        // Multi-cycle op followed by a single-cycle op.
        step(1'b1, 6'b111000, 1'b1, 1'b0);
        step(1'b1, 6'b110000, 1'b1, 1'b0);
        repeat (6) step(1'b0, 6'd0, 1'b1, 1'b0);

        // Queue up during a stall, then flush with an op offered.
        step(1'b1, 6'b111001, 1'b1, 1'b0);
        step(1'b1, 6'b000001, 1'b1, 1'b0);
        step(1'b1, 6'b010010, 1'b1, 1'b0);
        step(1'b1, 6'b110110, 1'b1, 1'b1);
        repeat (3) step(1'b0, 6'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stall with two entries queued.
        step(1'b1, 6'b111010, 1'b1, 1'b0);
        step(1'b1, 6'b000011, 1'b1, 1'b0);
        step(1'b1, 6'b110111, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_fields",    32'({out_alu_cnt, out_alu_use, out_cmp, out_class}), 32'd0);
        ref_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) step(1'b0, 6'd0, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) < 7),
                 6'($urandom),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 99) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered, flow-controlled ALU control decode stage; successor to the combinational opcode-to-ALU-control decoder. Sits between instruction fetch/issue and the ALU. Decodes the 6-bit major opcode into a 4-bit ALU control code plus class and usage flags, then buffers the result in a DEPTH-entry FIFO with valid/ready handshakes on both sides. Adds multi-cycle op throttling and pipeline flush, which the previous decoder did not have.

## Interface
Parameters:
- DEPTH, 2, number of decoded-entry slots; power of two, ≥2
- MC_MASK, 16'h0F00, bit k set ⇒ ALU code k is multi-cycle
- MC_CYCLES, 3, post-issue stall cycles for a multi-cycle op; 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  opcode offered
- in_ready  out  1  stage can accept
- in_op  in  6  instruction bits [5:0], major opcode
- out_valid  out  1  decoded entry offered
- out_ready  in  1  ALU accepts
- out_alu_cnt  out  4  ALU control code
- out_alu_use  out  1  instruction uses ALU
- out_cmp  out  1  compare; ALU result not written back
- out_class  out  2  0 load, 1 store, 2 branch/ctl, 3 ALU/IO
- busy  out  1  multi-cycle stall in progress

## Operation
- Decode (combinational, applied at push, stored decoded):
  - 00xxxx → cnt 0000, class 0, use 1
  - 01xxxx → cnt 0000, class 1, use 1
  - 10111x → cnt 0000, class 2, use 1
  - other 10xxxx → cnt 0000, class 2, use 0
  - 11xxxx → cnt = in_op[3:0], class 3, use 1; exception: 110101 (CMP) → cnt 0001, cmp 1
  - cmp = 0 for every other opcode
- FIFO: push on in_valid && in_ready; pop on out_valid && out_ready; count in 0..DEPTH, pointers wrap mod DEPTH.
- in_ready = (count < DEPTH) && !flush. Full: in_ready = 0; a simultaneous pop does not re-open in_ready in the same cycle.
- out_valid = (count ≠ 0) && (mc_cnt == 0). Output fields show the head entry; when count = 0 they hold the last value.
- Multi-cycle: a pop whose entry has use = 1 and MC_MASK[cnt] = 1 loads mc_cnt ← MC_CYCLES. mc_cnt decrements each cycle while nonzero. busy = (mc_cnt ≠ 0). Pushes continue during busy.
- Flush: next edge sets count ← 0, pointers ← 0, mc_cnt ← 0. Any push or pop offered in the flush cycle is discarded: in_ready is already 0, and a pop counts as no transfer.
- Empty with a simultaneous push and pop is impossible: out_valid = 0 when empty.

## Timing
- Reset (async assert, sync release): count 0, mc_cnt 0, out_valid 0, out_alu_cnt 0000, out_alu_use 0, out_cmp 0, out_class 00, busy 0, in_ready 1 after release.
- Latency: op pushed at edge N appears with out_valid = 1 in cycle N+1. No combinational in→out path.
- Throughput: 1 op/cycle when there are no multi-cycle ops.
- Multi-cycle op popped at edge N: out_valid = 0 for cycles N+1 … N+MC_CYCLES. Next entry is poppable at edge N+MC_CYCLES+1.
- Reset mid-stall or mid-fill: all state cleared immediately; no entry survives.

## Structure
- Shared package alu_pkg:
  - ALU code constants (ADD = 4'h0, SUB = 4'h1, SHIFT base = 4'h8, …)
  - opcode class enum (LOAD, STORE, CTL, ALU)
  - decoded-entry struct {cnt, use, cmp, class}
  - CMP opcode constant 6'b110101
- Sub-module alu_ctrl_decode: pure combinational decode (in_op → entry struct). The stage instantiates it once at the push side. It is reusable by the verification reference model.

## Test plan
- Reset, then push 110010, 000111, 011000 back-to-back with out_ready = 1 → outputs cnt 0010/3, 0000/0, 0000/1 on consecutive cycles, one cycle after each push.
- Push 110101, 101110, 100011 → (cnt 0001, cmp 1, class 3), (cnt 0000, use 1, class 2), (cnt 0000, use 0, class 2).
- Hold out_ready = 0, push 3 ops → in_ready drops after the 2nd. Release out_ready → order preserved; a pop while full does not accept that same cycle.
- Push 111000 then 110000, out_ready = 1 → 111000 pops at edge N, busy = 1 and out_valid = 0 for 3 cycles, 110000 pops at N+4.
- Fill 2 entries during a multi-cycle stall, assert flush with in_valid = 1 → next cycle count 0, busy 0, out_valid 0, flushed-cycle op not captured.
- Assert rst_n = 0 mid-stall with 2 entries queued → all outputs take their reset values asynchronously, in_ready = 1 after release.
